// File: rtl/des_tx_byte_packer.sv
// des_tx_byte_packer: splits one Triple-DES result block into bytes (MSB first)
// and writes them into the i2c_slave TX FIFO, stalling while the FIFO is full.
// Optional build macro TX_CHECKSUM_EN appends an XOR checksum byte per block.
module des_tx_byte_packer #(
  parameter int unsigned NUM_BYTES = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   block_valid,
  input  logic [8*NUM_BYTES-1:0] block_data,
  output logic                   block_ready,
  input  logic                   fifo_full,
  output logic                   write_enable,
  output logic [7:0]             write_data,
  output logic                   busy,
  output logic                   block_done,
  output logic [CNT_W-1:0]       blocks_sent
);

  localparam int unsigned BLK_W  = 8 * NUM_BYTES;
  localparam int unsigned BCNT_W = $clog2(NUM_BYTES + 1);

`ifdef TX_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [BLK_W-1:0]    shreg_q, shreg_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                block_done_q;
  logic [CNT_W-1:0]    blocks_sent_q;
`ifdef TX_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign block_done  = block_done_q;
  assign blocks_sent = blocks_sent_q;

  // Next-state, datapath updates and Mealy FIFO-write outputs
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_cnt_d   = byte_cnt_q;
`ifdef TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    block_ready  = 1'b0;
    busy         = 1'b0;
    write_enable = 1'b0;
    write_data   = 8'h00;

    case (state_q)
      IDLE: begin
        block_ready = 1'b1;
        if (block_valid) begin
          shreg_d    = block_data;
          byte_cnt_d = BCNT_W'(NUM_BYTES);
`ifdef TX_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
          state_d    = SEND;
        end
      end

      SEND: begin
        busy         = 1'b1;
        write_enable = !fifo_full;
        write_data   = shreg_q[BLK_W-1 -: 8];
        if (!fifo_full) begin
          shreg_d    = shreg_q << 8;
          byte_cnt_d = byte_cnt_q - BCNT_W'(1);
`ifdef TX_CHECKSUM_EN
          csum_d     = csum_q ^ shreg_q[BLK_W-1 -: 8];
`endif
          if (byte_cnt_q == BCNT_W'(1)) begin
`ifdef TX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end

`ifdef TX_CHECKSUM_EN
      CSUM: begin
        busy         = 1'b1;
        write_enable = !fifo_full;
        write_data   = csum_q;
        if (!fifo_full) begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and write outputs are forced quiet while reset is held
    if (rst) begin
      block_ready  = 1'b0;
      busy         = 1'b0;
      write_enable = 1'b0;
      write_data   = 8'h00;
    end
  end

  // State, shift register, counters; done pulse and count land on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      byte_cnt_q    <= '0;
      block_done_q  <= 1'b0;
      blocks_sent_q <= '0;
`ifdef TX_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_cnt_q   <= byte_cnt_d;
      block_done_q <= (state_d == DONE);
      if (state_d == DONE) begin
        blocks_sent_q <= blocks_sent_q + CNT_W'(1);
      end
`ifdef TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_des_tx_byte_packer.sv
// Bench for des_tx_byte_packer: reference byte stream is computed from the
// block value (MSB-first split, optional XOR trailer) and compared against
// every captured FIFO write. Honours TX_CHECKSUM_EN when defined.
module tb_des_tx_byte_packer;
  localparam int unsigned NB = 8;
  localparam int unsigned BW = 8 * NB;
`ifdef TX_CHECKSUM_EN
  localparam int WPB = NB + 1;
`else
  localparam int WPB = NB;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          block_valid = 1'b0;
  logic [BW-1:0] block_data = '0;
  logic          fifo_full = 1'b0;
  logic          block_ready, write_enable, busy, block_done;
  logic [7:0]    write_data;
  logic [15:0]   blocks_sent;
  logic          w_block_ready, w_write_enable, w_busy, w_block_done;
  logic [7:0]    w_write_data;
  logic [1:0]    w_blocks_sent;

  des_tx_byte_packer #(.NUM_BYTES(NB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_data(block_data),
    .block_ready(block_ready), .fifo_full(fifo_full), .write_enable(write_enable),
    .write_data(write_data), .busy(busy), .block_done(block_done),
    .blocks_sent(blocks_sent)
  );

  // Narrow-counter copy sharing the same stimulus, used for the wrap check
  des_tx_byte_packer #(.NUM_BYTES(NB), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_data(block_data),
    .block_ready(w_block_ready), .fifo_full(fifo_full), .write_enable(w_write_enable),
    .write_data(w_write_data), .busy(w_busy), .block_done(w_block_done),
    .blocks_sent(w_blocks_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stall_viol = 0;
  int full_cyc = 0;
  bq_t wq;
  int wcyc[$];
  int dcyc[$];
  int bs_q[$];
  int wbs_q[$];
  int stall_mode = 0;
  int burst_at = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture writes, done pulses and stall violations away from the edge
  always @(negedge clk) begin
    if (write_enable) begin
      wq.push_back(write_data);
      wcyc.push_back(cyc);
    end
    if (write_enable && fifo_full) stall_viol++;
    if (fifo_full && busy) full_cyc++;
    if (block_done) begin
      done_cnt++;
      dcyc.push_back(cyc);
      bs_q.push_back(int'(blocks_sent));
      wbs_q.push_back(int'(w_blocks_sent));
    end
  end

  // FIFO full generator
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      1: fifo_full = !fifo_full;
      2: fifo_full = 1'($urandom_range(0, 1));
      3: fifo_full = (wq.size() >= burst_at) && (burst_at > 0) &&
                     (cyc > wcyc[burst_at-1]) && (cyc <= wcyc[burst_at-1] + 5);
      default: fifo_full = 1'b0;
    endcase
  end

  function automatic bq_t model_bytes(input logic [BW-1:0] d);
    bq_t q;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      q.push_back(d[BW-1-8*i -: 8]);
      x = x ^ d[BW-1-8*i -: 8];
    end
`ifdef TX_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    block_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  // Present a block from a sample point; returns the cycle in which it was accepted
  task automatic send_block(input logic [BW-1:0] d, output int acc, output bit ok);
    ok = 1'b0;
    acc = -1;
    block_data = d;
    block_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (block_ready) begin
        ok = 1'b1;
        acc = cyc;
      end else begin
        tick();
      end
    end
    @(posedge clk);
    #1;
    block_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (block_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    block_valid = 1'b1;
    block_data = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    tick();
    checks++;
    if (write_enable !== 1'b0 || block_ready !== 1'b0 || busy !== 1'b0 || write_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_comb_outputs: we=%b rdy=%b busy=%b wd=%02h exp 0/0/0/00",
               write_enable, block_ready, busy, write_data);
    end
    checks++;
    if (blocks_sent !== 16'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: blocks_sent=%0d done=%b exp 0/0", blocks_sent, block_done);
    end
    @(posedge clk);
    #1;
    block_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (block_ready !== 1'b1 || busy !== 1'b0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b busy=%b we=%b exp 1/0/0", block_ready, busy, write_enable);
    end
  endtask

  task automatic test_basic();
    logic [BW-1:0] d;
    bq_t exp;
    int base, acc, bad, bi;
    bit ok, ok2;
    d = 64'h0123_4567_89AB_CDEF;
    reset_dut();
    base = wq.size();
    send_block(d, acc, ok);
    wait_done(ok2);
    checks++;
    if (!ok || !ok2) begin
      errors++;
      $display("FAIL basic_timeout: accepted=%b done=%b exp 1/1", ok, ok2);
    end
    exp = model_bytes(d);
    bad = 0;
    bi = -1;
    for (int i = 0; i < exp.size(); i++)
      if (base + i >= wq.size() || wq[base+i] !== exp[i]) begin bad = 1; bi = i; break; end
    checks++;
    if (bad != 0 || wq.size() != base + exp.size()) begin
      errors++;
      $display("FAIL basic_seq: writes=%0d exp %0d, first bad idx %0d", wq.size() - base, exp.size(), bi);
    end
    checks++;
    if (wq.size() >= base + 8 && (wq[base] !== 8'h01 || wq[base+7] !== 8'hEF)) begin
      errors++;
      $display("FAIL basic_ends: first=%02h last=%02h exp 01/EF", wq[base], wq[base+7]);
    end
    checks++;
    if (wcyc.size() <= base || wcyc[base] != acc + 1) begin
      errors++;
      $display("FAIL basic_first_write_latency: cycle=%0d exp %0d", (wcyc.size() > base) ? wcyc[base] : -1, acc + 1);
    end
    checks++;
    if (dcyc.size() == 0 || dcyc[$] != acc + 1 + WPB) begin
      errors++;
      $display("FAIL basic_done_latency: cycle=%0d exp %0d", (dcyc.size() > 0) ? dcyc[$] : -1, acc + 1 + WPB);
    end
    checks++;
    if (blocks_sent !== 16'd1 || block_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_state: blocks_sent=%0d rdy=%b busy=%b exp 1/0/1", blocks_sent, block_ready, busy);
    end
    tick();
    checks++;
    if (block_done !== 1'b0 || block_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done: done=%b rdy=%b busy=%b exp 0/1/0", block_done, block_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] d;
    bq_t exp;
    int base, acc, bad, v0, f0;
    bit ok, ok2;
    d = 64'h0123_4567_89AB_CDEF;
    base = wq.size();
    v0 = stall_viol;
    f0 = full_cyc;
    burst_at = base + 3;
    stall_mode = 3;
    send_block(d, acc, ok);
    wait_done(ok2);
    stall_mode = 0;
    burst_at = 0;
    checks++;
    if (!ok || !ok2) begin
      errors++;
      $display("FAIL bp_timeout: accepted=%b done=%b exp 1/1", ok, ok2);
    end
    exp = model_bytes(d);
    bad = (wq.size() != base + exp.size()) ? 1 : 0;
    for (int i = 0; i < exp.size() && bad == 0; i++)
      if (wq[base+i] !== exp[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_seq: writes=%0d exp %0d or byte order wrong", wq.size() - base, exp.size());
    end
    checks++;
    if (stall_viol != v0 || full_cyc - f0 != 5) begin
      errors++;
      $display("FAIL bp_stall: writes_while_full=%0d full_cycles=%0d exp 0/5", stall_viol - v0, full_cyc - f0);
    end
    checks++;
    if (dcyc.size() == 0 || dcyc[$] - acc != 1 + WPB + 5) begin
      errors++;
      $display("FAIL bp_done_latency: %0d exp %0d", (dcyc.size() > 0) ? dcyc[$] - acc : -1, 1 + WPB + 5);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bq_t exp, e2;
    int base, acc1, acc2, bs0, dn0, ready_in_done;
    bit ok1, ok2, ok3;
    reset_dut();
    base = wq.size();
    dn0 = done_cnt;
    bs0 = int'(blocks_sent);
    ready_in_done = 0;
    ok1 = 1'b0;
    ok2 = 1'b0;
    acc1 = -1;
    acc2 = -1;
    block_data = {BW{1'b1}};
    block_valid = 1'b1;
    for (int i = 0; i < 50 && !ok1; i++) begin
      if (block_ready) begin ok1 = 1'b1; acc1 = cyc; end else tick();
    end
    @(posedge clk);
    #1;
    block_data = '0;
    for (int i = 0; i < 100 && !ok2; i++) begin
      tick();
      if (block_done && block_ready) ready_in_done++;
      if (block_ready) begin ok2 = 1'b1; acc2 = cyc; end
    end
    @(posedge clk);
    #1;
    block_valid = 1'b0;
    wait_done(ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3) begin
      errors++;
      $display("FAIL b2b_timeout: acc1=%b acc2=%b done=%b exp 1/1/1", ok1, ok2, ok3);
    end
    checks++;
    if (acc2 - acc1 != WPB + 2 || ready_in_done != 0) begin
      errors++;
      $display("FAIL b2b_accept_period: %0d exp %0d, ready_in_done=%0d exp 0", acc2 - acc1, WPB + 2, ready_in_done);
    end
    exp = model_bytes({BW{1'b1}});
    e2 = model_bytes('0);
    foreach (e2[i]) exp.push_back(e2[i]);
    ok1 = (wq.size() == base + exp.size());
    for (int i = 0; i < exp.size() && ok1; i++)
      if (wq[base+i] !== exp[i]) ok1 = 1'b0;
    checks++;
    if (!ok1) begin
      errors++;
      $display("FAIL b2b_seq: writes=%0d exp %0d or byte order wrong", wq.size() - base, exp.size());
    end
    checks++;
    if (int'(blocks_sent) != bs0 + 2 || done_cnt != dn0 + 2) begin
      errors++;
      $display("FAIL b2b_count: blocks_sent=%0d pulses=%0d exp %0d/2", blocks_sent, done_cnt - dn0, bs0 + 2);
    end
    tick();
  endtask

  task automatic test_reset_mid_block();
    int base, acc, dn0;
    bit ok, got4;
    reset_dut();
    base = wq.size();
    dn0 = done_cnt;
    send_block(64'h1122_3344_5566_7788, acc, ok);
    got4 = 1'b0;
    for (int i = 0; i < 50 && !got4; i++) begin
      tick();
      if (wq.size() >= base + 4) got4 = 1'b1;
    end
    checks++;
    if (!ok || !got4) begin
      errors++;
      $display("FAIL rstmid_timeout: accepted=%b four_writes=%b exp 1/1", ok, got4);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (write_enable !== 1'b0 || block_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during: we=%b rdy=%b busy=%b exp 0/0/0", write_enable, block_ready, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (block_ready !== 1'b1 || busy !== 1'b0 || blocks_sent !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_after: rdy=%b busy=%b blocks_sent=%0d exp 1/0/0", block_ready, busy, blocks_sent);
    end
    repeat (15) tick();
    checks++;
    if (wq.size() != base + 4 || wq[$] !== 8'h44 || done_cnt != dn0 || blocks_sent !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_discard: writes=%0d last=%02h pulses=%0d exp 4/44/0",
               wq.size() - base, wq[$], done_cnt - dn0);
    end
  endtask

`ifdef TX_CHECKSUM_EN
  task automatic test_checksum();
    int base, acc;
    bit ok1, ok2, ok3, ok4;
    base = wq.size();
    send_block(64'h0123_4567_89AB_CDEF, acc, ok1);
    wait_done(ok2);
    tick();
    send_block(64'h0100_0000_0000_0000, acc, ok3);
    wait_done(ok4);
    tick();
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4) || wq.size() != base + 18) begin
      errors++;
      $display("FAIL csum_count: writes=%0d exp 18", wq.size() - base);
    end else begin
      checks++;
      if (wq[base+8] !== 8'h00 || wq[base+17] !== 8'h01) begin
        errors++;
        $display("FAIL csum_value: got %02h/%02h exp 00/01", wq[base+8], wq[base+17]);
      end
    end
  endtask
`endif

  task automatic test_stalled_stream(input int mode, input int nblk, input string tag);
    bq_t exp, e;
    int base, acc, dn0, bs0, v0, tmo, bad;
    bit ok;
    logic [BW-1:0] d;
    base = wq.size();
    dn0 = done_cnt;
    bs0 = int'(blocks_sent);
    v0 = stall_viol;
    tmo = 0;
    stall_mode = mode;
    for (int b = 0; b < nblk; b++) begin
      d = {$urandom, $urandom};
      e = model_bytes(d);
      foreach (e[i]) exp.push_back(e[i]);
      send_block(d, acc, ok);
      if (!ok) tmo++;
      wait_done(ok);
      if (!ok) tmo++;
      repeat ($urandom_range(0, 3)) tick();
    end
    stall_mode = 0;
    tick();
    checks++;
    if (tmo != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expired waits exp 0", tag, tmo);
    end
    bad = (wq.size() != base + exp.size()) ? 1 : 0;
    for (int i = 0; i < exp.size() && bad == 0; i++)
      if (wq[base+i] !== exp[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_seq: writes=%0d exp %0d or byte order wrong", tag, wq.size() - base, exp.size());
    end
    checks++;
    if (stall_viol != v0 || done_cnt != dn0 + nblk || int'(blocks_sent) != bs0 + nblk) begin
      errors++;
      $display("FAIL %s_count: writes_while_full=%0d pulses=%0d blocks_sent=%0d exp 0/%0d/%0d",
               tag, stall_viol - v0, done_cnt - dn0, blocks_sent, nblk, bs0 + nblk);
    end
  endtask

  task automatic test_wrap();
    int exp_w[5];
    int d0, acc;
    bit ok, all_ok;
    exp_w = '{1, 2, 3, 0, 1};
    reset_dut();
    d0 = wbs_q.size();
    all_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      send_block({$urandom, $urandom}, acc, ok);
      all_ok &= ok;
      wait_done(ok);
      all_ok &= ok;
      tick();
    end
    checks++;
    if (!all_ok || wbs_q.size() != d0 + 5) begin
      errors++;
      $display("FAIL wrap_timeout: pulses=%0d exp 5", wbs_q.size() - d0);
    end else begin
      for (int b = 0; b < 5; b++) begin
        checks++;
        if (wbs_q[d0+b] != exp_w[b] || bs_q[d0+b] != b + 1) begin
          errors++;
          $display("FAIL wrap_count%0d: narrow=%0d wide=%0d exp %0d/%0d",
                   b, wbs_q[d0+b], bs_q[d0+b], exp_w[b], b + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
`ifdef TX_CHECKSUM_EN
    test_checksum();
`endif
    test_stalled_stream(1, 3, "toggle");
    test_stalled_stream(2, 6, "random");
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/des_tx_byte_packer.md
Name: des_tx_byte_packer

Overview:
- Upstream feeder for the I2C slave transmit FIFO.
- Accepts one 64-bit Triple-DES result block per handshake and splits it into bytes, most significant byte first.
- Writes the bytes into the slave's TX FIFO through its write_enable/write_data port, pausing whenever the FIFO reports full.
- Sits between the Triple-DES core output and i2c_slave.

Parameters:
- NUM_BYTES, 8, bytes per input block; block width is 8*NUM_BYTES.
- CNT_W, 16, width of the blocks_sent counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- block_valid  input  1  DES core presents a block.
- block_data  input  8*NUM_BYTES  block contents; byte [8*NUM_BYTES-1 -: 8] is sent first.
- block_ready  output  1  packer can accept a block.
- fifo_full  input  1  TX FIFO full flag from i2c_slave; already reflects a write made on the preceding edge.
- write_enable  output  1  one FIFO write per asserted cycle.
- write_data  output  8  byte written when write_enable=1.
- busy  output  1  block in progress.
- block_done  output  1  one-cycle pulse after the final byte (and checksum, if enabled) is written.
- blocks_sent  output  CNT_W  count of completed blocks; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled at the rising edge of clk:
  - state=IDLE; shift register, byte counter and checksum cleared.
  - Registered outputs: blocks_sent=0, block_done=0.
  - Combinational outputs while rst=1: write_enable=0, write_data=0, block_ready=0, busy=0.
- States: IDLE, SEND, CSUM (checksum build only), DONE.
- IDLE:
  - block_ready=1, busy=0.
  - On block_valid & block_ready: latch block_data, byte_cnt=NUM_BYTES, checksum=0, go to SEND.
  - block_valid while not ready is ignored. The DES core must hold the block until accepted.
- SEND:
  - write_enable = !fifo_full (Mealy); write_data = top byte of the shift register.
  - On each edge with write_enable=1: shift left 8, byte_cnt-1, checksum ^= write_data.
  - fifo_full=1 stalls: write_enable=0, no state change, write_data held.
  - Last byte written (byte_cnt==1 and write_enable=1):
    - to CSUM if TX_CHECKSUM_EN is defined;
    - to DONE otherwise.
- CSUM:
  - write_enable = !fifo_full; write_data = accumulated XOR checksum.
  - Go to DONE on a write; stall as in SEND.
- DONE (exactly one cycle):
  - block_done=1 and blocks_sent+1 take effect registered on entry, so both are visible during the DONE cycle.
  - block_ready=0, busy=1. Go to IDLE.
- busy=1 in SEND/CSUM/DONE; block_ready=1 only in IDLE.
- Latency:
  - Accept edge to first write_enable: 1 cycle, FIFO not full.
  - Full block with no stalls: NUM_BYTES write cycles (+1 with checksum), plus one DONE cycle.
  - Minimum block period: NUM_BYTES+2 cycles (+1 with checksum).
- Boundaries:
  - fifo_full toggling every cycle: bytes are still written in order, none dropped or duplicated.
  - fifo_full rising in the same cycle as the last byte: no write, the packer waits.
  - blocks_sent wraps from 2^CNT_W-1 to 0.
  - rst mid-block: the partial block is discarded, no further writes, back to IDLE on the next edge.
  - A block_valid held high across DONE is accepted in the following IDLE cycle, not during DONE.

Optional Feature:
- Macro: TX_CHECKSUM_EN.
- Defined: an extra byte equal to the XOR of all NUM_BYTES data bytes is written after each block, via state CSUM, so 9 FIFO writes occur per block at default parameters.
- Undefined: the CSUM state and checksum register are absent; exactly NUM_BYTES writes per block.

Test Plan:
- Basic block:
  - Stimulus: after rst, block 64'h0123_4567_89AB_CDEF, fifo_full=0.
  - Response: write_data sequence 01,23,45,67,89,AB,CD,EF on 8 consecutive write_enable cycles; block_done pulses one cycle later; blocks_sent=1.
- Backpressure:
  - Stimulus: same block, fifo_full=1 for 5 cycles after the 3rd byte.
  - Response: write_enable=0 for those 5 cycles; remaining bytes 67..EF follow unchanged; total 8 writes.
- Back-to-back blocks:
  - Stimulus: block_valid held high with 64'hFFFF_FFFF_FFFF_FFFF, then 64'h0.
  - Response: second accept occurs in the IDLE cycle after DONE; 16 writes in order; blocks_sent=2.
- Reset mid-block:
  - Stimulus: rst=1 for one cycle after the 4th byte of 64'h1122_3344_5566_7788.
  - Response: no write of 55; block_ready=1 the cycle after rst falls; blocks_sent=0; block_done never pulses.
- Checksum build (TX_CHECKSUM_EN defined):
  - Stimulus: block 64'h0123_4567_89AB_CDEF.
  - Response: 9 writes, the last equal to 8'h00 (XOR of the bytes); second block 64'h0100_0000_0000_0000 gives last byte 8'h01.
- Counter wrap:
  - Stimulus: CNT_W=2, send 5 blocks.
  - Response: blocks_sent sequence 1,2,3,0,1.
